// File: rtl/hdr_merge_core.sv
// hdr_merge_core: per-pixel HDR radiance merge.
// For each of CH channels computes sum_e(w_e*(g_e+lnexp_e)) / sum_e(w_e) in unsigned fixed
// point (FP fraction bits). Exposures are accumulated one per cycle, then every channel runs
// a lock-step restoring divider (one quotient bit per cycle). The result is saturated to N
// bits, and a zero weight sum is flagged.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready is high only while idle
//   g_in, w_in          response and weight, slice (c*NUM_EXP+e)*N
//   ln_exp              log exposure time per exposure, slice e*N
//   out_valid/out_ready output handshake
//   out_le              merged log-radiance per channel, slice c*N
//   out_sat, out_zero_w per-channel clamp and zero-weight flags
module hdr_merge_core #(
  parameter int unsigned N       = 8,
  parameter int unsigned FP      = 4,
  parameter int unsigned NUM_EXP = 3,
  parameter int unsigned CH      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH*NUM_EXP*N-1:0] g_in,
  input  logic [CH*NUM_EXP*N-1:0] w_in,
  input  logic [NUM_EXP*N-1:0]    ln_exp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH*N-1:0]         out_le,
  output logic [CH-1:0]           out_sat,
  output logic [CH-1:0]           out_zero_w
);

  localparam int unsigned EW    = $clog2(NUM_EXP);
  localparam int unsigned ACC_W = 2 * N + 1 + EW;
  localparam int unsigned DW    = ACC_W + FP;
  localparam int unsigned WS_W  = N + EW;
  localparam int unsigned CW    = $clog2(DW);
  localparam int unsigned PW    = 2 * N + 1;
  localparam int unsigned GW    = CH * NUM_EXP * N;
  localparam int unsigned LW    = NUM_EXP * N;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDiv   = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [GW-1:0]    g_q, g_d, w_q, w_d;
  logic [LW-1:0]    ln_q, ln_d;
  logic [EW-1:0]    e_q, e_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q [CH];
  logic [ACC_W-1:0] acc_d [CH];
  logic [WS_W-1:0]  wsum_q [CH];
  logic [WS_W-1:0]  wsum_d [CH];
  logic [WS_W-1:0]  rem_q [CH];
  logic [WS_W-1:0]  rem_d [CH];
  logic [DW-1:0]    quo_q [CH];
  logic [DW-1:0]    quo_d [CH];
  logic [CH*N-1:0]  le_q, le_d;
  logic [CH-1:0]    sat_q, sat_d, zw_q, zw_d;

  // Datapath temporaries, one set per channel
  logic [N-1:0]     ln_cur;
  logic [N-1:0]     g_cur  [CH];
  logic [N-1:0]     w_cur  [CH];
  logic [N:0]       diff   [CH];
  logic [PW-1:0]    prod   [CH];
  logic [DW-1:0]    dvd    [CH];
  logic [WS_W:0]    trial  [CH];
  logic             qbit   [CH];
  logic [WS_W-1:0]  rem_nx [CH];
  logic [DW-1:0]    quo_nx [CH];

  always_comb begin
    ln_cur = ln_q[int'(e_q)*N +: N];
    for (int c = 0; c < CH; c++) begin
      g_cur[c] = g_q[(c * NUM_EXP + int'(e_q)) * N +: N];
      w_cur[c] = w_q[(c * NUM_EXP + int'(e_q)) * N +: N];
      // N+1 bits holds the full sum, so the log-domain add never wraps
      diff[c]  = {1'b0, g_cur[c]} + {1'b0, ln_cur};
      prod[c]  = PW'(diff[c]) * PW'(w_cur[c]);
      // Restoring division step: dividend bits are fed MSB first from acc<<FP
      dvd[c]   = {acc_q[c], {FP{1'b0}}};
      trial[c] = {rem_q[c], dvd[c][DW-1-int'(cnt_q)]};
      qbit[c]  = (trial[c] >= {1'b0, wsum_q[c]});
      // With wsum==0 the remainder is meaningless; that case is flagged, not used
      rem_nx[c] = qbit[c] ? WS_W'(trial[c] - {1'b0, wsum_q[c]}) : WS_W'(trial[c]);
      quo_nx[c] = {quo_q[c][DW-2:0], qbit[c]};
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    w_d     = w_q;
    ln_d    = ln_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    le_d    = le_q;
    sat_d   = sat_q;
    zw_d    = zw_q;
    for (int c = 0; c < CH; c++) begin
      acc_d[c]  = acc_q[c];
      wsum_d[c] = wsum_q[c];
      rem_d[c]  = rem_q[c];
      quo_d[c]  = quo_q[c];
    end

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          g_d  = g_in;
          w_d  = w_in;
          ln_d = ln_exp;
          e_d  = '0;
          for (int c = 0; c < CH; c++) begin
            acc_d[c]  = '0;
            wsum_d[c] = '0;
          end
          state_d = StAccum;
        end
      end
      StAccum: begin
        for (int c = 0; c < CH; c++) begin
          acc_d[c]  = acc_q[c] + ACC_W'(prod[c] >> FP);
          wsum_d[c] = wsum_q[c] + WS_W'(w_cur[c]);
        end
        if (e_q == EW'(NUM_EXP - 1)) begin
          cnt_d = '0;
          for (int c = 0; c < CH; c++) begin
            rem_d[c] = '0;
            quo_d[c] = '0;
          end
          state_d = StDiv;
        end else begin
          e_d = e_q + 1'b1;
        end
      end
      StDiv: begin
        for (int c = 0; c < CH; c++) begin
          rem_d[c] = rem_nx[c];
          quo_d[c] = quo_nx[c];
        end
        if (cnt_q == CW'(DW - 1)) begin
          // Last quotient bit: resolve flags and clamp straight from the next quotient
          for (int c = 0; c < CH; c++) begin
            if (wsum_q[c] == '0) begin
              le_d[c*N +: N] = '0;
              sat_d[c]       = 1'b0;
              zw_d[c]        = 1'b1;
            end else if (quo_nx[c][DW-1:N] != '0) begin
              le_d[c*N +: N] = '1;
              sat_d[c]       = 1'b1;
              zw_d[c]        = 1'b0;
            end else begin
              le_d[c*N +: N] = quo_nx[c][N-1:0];
              sat_d[c]       = 1'b0;
              zw_d[c]        = 1'b0;
            end
          end
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      g_q     <= '0;
      w_q     <= '0;
      ln_q    <= '0;
      e_q     <= '0;
      cnt_q   <= '0;
      le_q    <= '0;
      sat_q   <= '0;
      zw_q    <= '0;
      for (int c = 0; c < CH; c++) begin
        acc_q[c]  <= '0;
        wsum_q[c] <= '0;
        rem_q[c]  <= '0;
        quo_q[c]  <= '0;
      end
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      w_q     <= w_d;
      ln_q    <= ln_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      le_q    <= le_d;
      sat_q   <= sat_d;
      zw_q    <= zw_d;
      for (int c = 0; c < CH; c++) begin
        acc_q[c]  <= acc_d[c];
        wsum_q[c] <= wsum_d[c];
        rem_q[c]  <= rem_d[c];
        quo_q[c]  <= quo_d[c];
      end
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StHold);
  assign out_le     = le_q;
  assign out_sat    = sat_q;
  assign out_zero_w = zw_q;

endmodule

// File: tb/tb_hdr_merge_core.sv
// Testbench for hdr_merge_core: directed scenarios plus randomized pixels, scoreboard checked
// by an independent output monitor.
module tb_hdr_merge_core;

  localparam int N       = 8;
  localparam int FP      = 4;
  localparam int NUM_EXP = 3;
  localparam int CH      = 3;
  localparam int ACC_W   = 2 * N + 1 + $clog2(NUM_EXP);
  localparam int DW      = ACC_W + FP;
  localparam int LAT     = NUM_EXP + DW + 1;
  localparam int GW      = CH * NUM_EXP * N;
  localparam int LW      = NUM_EXP * N;

  typedef struct {
    logic [CH*N-1:0] le;
    logic [CH-1:0]   sat;
    logic [CH-1:0]   zw;
    int              acc_cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [GW-1:0]   g_in;
  logic [GW-1:0]   w_in;
  logic [LW-1:0]   ln_exp;
  logic            out_valid;
  logic            out_ready;
  logic [CH*N-1:0] out_le;
  logic [CH-1:0]   out_sat;
  logic [CH-1:0]   out_zero_w;

  hdr_merge_core #(.N(N), .FP(FP), .NUM_EXP(NUM_EXP), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .g_in      (g_in),
    .w_in      (w_in),
    .ln_exp    (ln_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_le    (out_le),
    .out_sat   (out_sat),
    .out_zero_w(out_zero_w)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   ov_prev = 1'b0;
  int   last_hs = 0;
  logic [CH*N-1:0] last_le = '0;
  bit   rdy_rand = 1'b0;
  bit   rdy_val = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  // Reference: weighted average in plain integer arithmetic
  function automatic exp_t model(input logic [GW-1:0] gv, input logic [GW-1:0] wv,
                                 input logic [LW-1:0] lv);
    exp_t r;
    r.le = '0;
    r.sat = '0;
    r.zw = '0;
    r.acc_cyc = 0;
    for (int c = 0; c < CH; c++) begin
      longint acc;
      longint ws;
      longint q;
      acc = 0;
      ws = 0;
      for (int e = 0; e < NUM_EXP; e++) begin
        longint gi, wi, li;
        gi = longint'(gv[(c*NUM_EXP+e)*N +: N]);
        wi = longint'(wv[(c*NUM_EXP+e)*N +: N]);
        li = longint'(lv[e*N +: N]);
        acc += ((gi + li) * wi) / (64'd1 << FP);
        ws += wi;
      end
      if (ws == 0) begin
        r.zw[c] = 1'b1;
      end else begin
        q = (acc * (64'd1 << FP)) / ws;
        if (q > (2**N - 1)) begin
          r.le[c*N +: N] = '1;
          r.sat[c] = 1'b1;
        end else begin
          r.le[c*N +: N] = N'(q);
        end
      end
    end
    return r;
  endfunction

  // Present a pixel until accepted; push its expected result at the accept edge
  task automatic send(input logic [GW-1:0] gv, input logic [GW-1:0] wv,
                      input logic [LW-1:0] lv, input logic [CH*N-1:0] ele,
                      input logic [CH-1:0] esat, input logic [CH-1:0] ezw,
                      output int acc_at);
    exp_t x;
    bit ok;
    int waited;
    g_in = gv;
    w_in = wv;
    ln_exp = lv;
    in_valid = 1'b1;
    ok = 1'b0;
    waited = 0;
    acc_at = -1;
    while (!ok && waited < 300) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      waited++;
    end
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      x.le = ele;
      x.sat = esat;
      x.zw = ezw;
      x.acc_cyc = cyc;
      acc_at = cyc;
      sb.push_back(x);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 600) begin
      @(posedge clk);
      t++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: latency on rise, value compare on handshake
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("spurious_out_valid", 64'(out_valid), 64'd0);
        else chk("latency", 64'(cyc - sb[0].acc_cyc + 1), 64'(LAT));
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("out_le", 64'(out_le), 64'(mon_e.le));
        chk("out_sat", 64'(out_sat), 64'(mon_e.sat));
        chk("out_zero_w", 64'(out_zero_w), 64'(mon_e.zw));
        last_le = out_le;
        last_hs = cyc + 1;
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [GW-1:0] gv_nom, wv_nom, wv_z, gv_s, wv_s, gv_r, wv_r;
    logic [LW-1:0] lv_nom, lv_r;
    logic [CH*N-1:0] le_nom;
    logic [CH*N-1:0] hold_le;
    logic [CH-1:0] hold_sat, hold_zw;
    exp_t er;
    int acc_a, acc_b, t;

    gv_nom = {9{8'd10}};
    wv_nom = {9{8'd16}};
    lv_nom = {8'd76, 8'd65, 8'd54};
    le_nom = {8'd75, 8'd75, 8'd75};
    wv_z = wv_nom;
    for (int e = 0; e < NUM_EXP; e++) wv_z[(1*NUM_EXP+e)*N +: N] = '0;
    gv_s = gv_nom;
    wv_s = wv_nom;
    for (int e = 0; e < 2; e++) wv_s[(2*NUM_EXP+e)*N +: N] = '0;
    gv_s[(2*NUM_EXP+2)*N +: N] = 8'd250;

    rst = 1'b1;
    in_valid = 1'b0;
    g_in = '0;
    w_in = '0;
    ln_exp = '0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_le", 64'(out_le), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    chk("rst_out_zero_w", 64'(out_zero_w), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Nominal
    send(gv_nom, wv_nom, lv_nom, le_nom, 3'b000, 3'b000, acc_a);
    drain();
    // Zero weight on channel 1
    send(gv_nom, wv_z, lv_nom, {8'd75, 8'd0, 8'd75}, 3'b000, 3'b010, acc_a);
    drain();
    // Saturation on channel 2
    send(gv_s, wv_s, lv_nom, {8'd255, 8'd75, 8'd75}, 3'b100, 3'b000, acc_a);
    drain();

    // Backpressure with a second pixel waiting
    rdy_val = 1'b0;
    @(posedge clk);
    #1;
    send(gv_nom, wv_nom, lv_nom, le_nom, 3'b000, 3'b000, acc_a);
    fork
      begin
        send(gv_nom, wv_z, lv_nom, {8'd75, 8'd0, 8'd75}, 3'b000, 3'b010, acc_b);
      end
      begin
        t = 0;
        while (!out_valid && t < 100) begin
          @(negedge clk);
          t++;
        end
        chk("bp_out_valid_rise", 64'(out_valid), 64'd1);
        hold_le = out_le;
        hold_sat = out_sat;
        hold_zw = out_zero_w;
        repeat (5) begin
          @(negedge clk);
          chk("bp_out_le_stable", 64'(out_le), 64'(hold_le));
          chk("bp_out_sat_stable", 64'(out_sat), 64'(hold_sat));
          chk("bp_out_zero_w_stable", 64'(out_zero_w), 64'(hold_zw));
          chk("bp_in_ready_low", 64'(in_ready), 64'd0);
          chk("bp_out_valid_held", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        rdy_val = 1'b1;
      end
    join
    chk("bp_accept_after_hs", 64'(acc_b - last_hs), 64'd1);
    drain();

    // Reset during the divide
    send(gv_nom, wv_nom, lv_nom, le_nom, 3'b000, 3'b000, acc_a);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    send(gv_nom, wv_nom, lv_nom, le_nom, 3'b000, 3'b000, acc_a);
    drain();

    // Inputs changed while accumulating must not affect the result
    send(gv_nom, wv_nom, lv_nom, le_nom, 3'b000, 3'b000, acc_a);
    ln_exp = {8'd3, 8'd200, 8'd1};
    g_in = {9{8'd99}};
    w_in = {9{8'd7}};
    @(posedge clk);
    #1;
    ln_exp = {8'd250, 8'd0, 8'd128};
    drain();

    // Randomized pixels with random backpressure
    rdy_rand = 1'b1;
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < CH * NUM_EXP; i++) begin
        gv_r[i*N +: N] = N'($urandom_range(0, 255));
        wv_r[i*N +: N] = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom_range(1, 255));
      end
      if ($urandom_range(0, 5) == 0) begin
        for (int e = 0; e < NUM_EXP; e++) wv_r[(0*NUM_EXP+e)*N +: N] = '0;
      end
      for (int e = 0; e < NUM_EXP; e++) lv_r[e*N +: N] = N'($urandom_range(0, 255));
      er = model(gv_r, wv_r, lv_r);
      send(gv_r, wv_r, lv_r, er.le, er.sat, er.zw, acc_a);
      g_in = {$urandom, $urandom, $urandom};
      w_in = {$urandom, $urandom, $urandom};
      ln_exp = N'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_rand = 1'b0;
    rdy_val = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_after_hs", 64'(out_le), 64'(last_le));
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
